// File: rtl/paddle_pkg.sv
// Shared types and elaboration helpers for the paddle array controller.
package paddle_pkg;

  typedef enum logic [1:0] {StIdle, StSlow, StFast} state_e;
  typedef enum logic [1:0] {DirNone, DirDec, DirInc} dir_e;

  // Largest legal left-edge coordinate for a paddle of the given length.
  function automatic int unsigned max_left(input int unsigned field_max,
                                           input int unsigned len);
    return field_max - len + 1;
  endfunction

  function automatic int unsigned hold_width(input int unsigned accel_ticks);
    return ($clog2(accel_ticks + 1) < 1) ? 1 : $clog2(accel_ticks + 1);
  endfunction

endpackage

// File: rtl/paddle_channel.sv
// One paddle: button synchroniser, slow/fast motion FSM and saturating position register.
module paddle_channel
  import paddle_pkg::*;
#(
  parameter int unsigned POS_W       = 9,
  parameter int unsigned MAX_LEFT    = 200,
  parameter int unsigned INIT_POS    = 100,
  parameter int unsigned PADDLE_LEN  = 40,
  parameter int unsigned SPEED_SLOW  = 1,
  parameter int unsigned SPEED_FAST  = 3,
  parameter int unsigned ACCEL_TICKS = 8
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             tick_i,
  input  logic             freeze_i,
  input  logic             recenter_i,
  input  logic             btn_dec_i,
  input  logic             btn_inc_i,
  output logic [POS_W-1:0] pos_left_o,
  output logic [POS_W-1:0] pos_centre_o,
  output logic             moving_o,
  output logic             at_min_o,
  output logic             at_max_o
);

  localparam int unsigned      HoldW      = hold_width(ACCEL_TICKS);
  localparam logic [HoldW-1:0] HoldAccel  = HoldW'(ACCEL_TICKS);
  localparam logic [POS_W:0]   MaxLeftExt = (POS_W + 1)'(MAX_LEFT);

  logic [1:0]       dec_sync_q, inc_sync_q;
  state_e           state_q, state_d;
  dir_e             dir_q, dir_d, dir_in, move_dir;
  logic             move_fast;
  logic [HoldW-1:0] hold_q, hold_d;
  logic [POS_W-1:0] pos_q, pos_d;
  logic [POS_W:0]   pos_ext, step_ext, sum_ext;

  always_ff @(posedge clock) begin
    if (reset) begin
      dec_sync_q <= '0;
      inc_sync_q <= '0;
      state_q    <= StIdle;
      dir_q      <= DirNone;
      hold_q     <= '0;
      pos_q      <= POS_W'(INIT_POS);
    end else begin
      dec_sync_q <= {dec_sync_q[0], btn_dec_i};
      inc_sync_q <= {inc_sync_q[0], btn_inc_i};
      state_q    <= state_d;
      dir_q      <= dir_d;
      hold_q     <= hold_d;
      pos_q      <= pos_d;
    end
  end

  // Both buttons pressed cancel out.
  always_comb begin
    case ({inc_sync_q[1], dec_sync_q[1]})
      2'b10:   dir_in = DirInc;
      2'b01:   dir_in = DirDec;
      default: dir_in = DirNone;
    endcase
  end

  always_comb begin
    state_d   = state_q;
    dir_d     = dir_q;
    hold_d    = hold_q;
    move_dir  = DirNone;
    move_fast = 1'b0;
    if (recenter_i || freeze_i) begin
      state_d = StIdle;
      dir_d   = DirNone;
      hold_d  = '0;
    end else if (tick_i) begin
      if (dir_in == DirNone) begin
        state_d = StIdle;
        dir_d   = DirNone;
        hold_d  = '0;
      end else if (state_q == StIdle || dir_in != dir_q) begin
        // Fresh press or reversal always restarts at slow speed.
        move_dir = dir_in;
        dir_d    = dir_in;
        hold_d   = HoldW'(1);
        state_d  = (ACCEL_TICKS <= 1) ? StFast : StSlow;
      end else if (state_q == StSlow) begin
        move_dir = dir_in;
        hold_d   = hold_q + 1'b1;
        if (hold_d >= HoldAccel) state_d = StFast;
      end else begin
        move_dir  = dir_in;
        move_fast = 1'b1;
      end
    end
  end

  // Widened by one bit so the saturation tests cannot wrap.
  always_comb begin
    pos_ext  = {1'b0, pos_q};
    step_ext = move_fast ? (POS_W + 1)'(SPEED_FAST) : (POS_W + 1)'(SPEED_SLOW);
    sum_ext  = pos_ext + step_ext;
    pos_d    = pos_q;
    if (recenter_i) begin
      pos_d = POS_W'(INIT_POS);
    end else if (move_dir == DirDec) begin
      pos_d = (pos_ext < step_ext) ? '0 : POS_W'(pos_ext - step_ext);
    end else if (move_dir == DirInc) begin
      pos_d = (sum_ext > MaxLeftExt) ? POS_W'(MAX_LEFT) : sum_ext[POS_W-1:0];
    end
  end

  assign pos_left_o   = pos_q;
  assign pos_centre_o = pos_q + POS_W'(PADDLE_LEN / 2) - POS_W'(1);
  assign moving_o     = (state_q != StIdle);
  assign at_min_o     = (pos_q == '0);
  assign at_max_o     = (pos_q == POS_W'(MAX_LEFT));

endmodule

// File: rtl/paddle_array_ctrl.sv
// Paddle array: shared frame tick divider, control fan-out and per-paddle output packing.
module paddle_array_ctrl
  import paddle_pkg::*;
#(
  parameter int unsigned NUM_PADDLES = 2,
  parameter int unsigned POS_W       = 9,
  parameter int unsigned FIELD_MAX   = 239,
  parameter int unsigned PADDLE_LEN  = 40,
  parameter int unsigned INIT_POS    = 100,
  parameter int unsigned TICK_DIV    = 833333,
  parameter int unsigned SPEED_SLOW  = 1,
  parameter int unsigned SPEED_FAST  = 3,
  parameter int unsigned ACCEL_TICKS = 8
) (
  input  logic                         clock,
  input  logic                         reset,
  input  logic [NUM_PADDLES-1:0]       btn_dec_i,
  input  logic [NUM_PADDLES-1:0]       btn_inc_i,
  input  logic                         freeze_i,
  input  logic                         recenter_i,
  output logic [NUM_PADDLES*POS_W-1:0] pos_left_o,
  output logic [NUM_PADDLES*POS_W-1:0] pos_centre_o,
  output logic [NUM_PADDLES-1:0]       moving_o,
  output logic [NUM_PADDLES-1:0]       at_min_o,
  output logic [NUM_PADDLES-1:0]       at_max_o
);

  localparam int unsigned MaxLeft = max_left(FIELD_MAX, PADDLE_LEN);
  localparam int unsigned TickW   = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;

  if (PADDLE_LEN > FIELD_MAX + 1 || INIT_POS > MaxLeft || SPEED_SLOW < 1 ||
      SPEED_FAST < SPEED_SLOW || TICK_DIV < 1) begin : g_param_check
    $fatal(1, "paddle_array_ctrl: illegal parameter combination");
  end

  logic [TickW-1:0] tick_cnt_q, tick_cnt_d;
  logic             tick;

  // Free-running: freeze and recenter do not disturb the frame phase.
  assign tick       = (tick_cnt_q == TickW'(TICK_DIV - 1));
  assign tick_cnt_d = tick ? '0 : tick_cnt_q + 1'b1;

  always_ff @(posedge clock) begin
    if (reset) tick_cnt_q <= '0;
    else       tick_cnt_q <= tick_cnt_d;
  end

  for (genvar i = 0; i < NUM_PADDLES; i++) begin : g_chan
    paddle_channel #(
      .POS_W      (POS_W),
      .MAX_LEFT   (MaxLeft),
      .INIT_POS   (INIT_POS),
      .PADDLE_LEN (PADDLE_LEN),
      .SPEED_SLOW (SPEED_SLOW),
      .SPEED_FAST (SPEED_FAST),
      .ACCEL_TICKS(ACCEL_TICKS)
    ) u_chan (
      .clock       (clock),
      .reset       (reset),
      .tick_i      (tick),
      .freeze_i    (freeze_i),
      .recenter_i  (recenter_i),
      .btn_dec_i   (btn_dec_i[i]),
      .btn_inc_i   (btn_inc_i[i]),
      .pos_left_o  (pos_left_o[i*POS_W +: POS_W]),
      .pos_centre_o(pos_centre_o[i*POS_W +: POS_W]),
      .moving_o    (moving_o[i]),
      .at_min_o    (at_min_o[i]),
      .at_max_o    (at_max_o[i])
    );
  end

endmodule

// File: tb/tb_paddle_array_ctrl.sv
// Directed and randomised checks of paddle_array_ctrl against a run-length motion model.
module tb_paddle_array_ctrl;

  localparam int NP   = 2;
  localparam int PW   = 9;
  localparam int TD   = 4;
  localparam int INIT = 100;
  localparam int MAXL = 200;
  localparam int HALF = 20;
  localparam int ACC  = 8;
  localparam int SS   = 1;
  localparam int SF   = 3;

  logic             clock = 1'b0;
  logic             reset = 1'b1;
  logic [NP-1:0]    btn_dec = '0;
  logic [NP-1:0]    btn_inc = '0;
  logic             freeze = 1'b0;
  logic             recenter = 1'b0;
  logic [NP*PW-1:0] pos_left, pos_centre;
  logic [NP-1:0]    moving, at_min, at_max;

  paddle_array_ctrl #(
    .NUM_PADDLES(NP),
    .POS_W      (PW),
    .FIELD_MAX  (239),
    .PADDLE_LEN (40),
    .INIT_POS   (INIT),
    .TICK_DIV   (TD),
    .SPEED_SLOW (SS),
    .SPEED_FAST (SF),
    .ACCEL_TICKS(ACC)
  ) dut (
    .clock       (clock),
    .reset       (reset),
    .btn_dec_i   (btn_dec),
    .btn_inc_i   (btn_inc),
    .freeze_i    (freeze),
    .recenter_i  (recenter),
    .pos_left_o  (pos_left),
    .pos_centre_o(pos_centre),
    .moving_o    (moving),
    .at_min_o    (at_min),
    .at_max_o    (at_max)
  );

  always #5 clock = ~clock;

  int total = 0;
  int passed = 0;

  // Model: per paddle, position plus the length of the current same-direction move run.
  int            m_pos[NP];
  int            m_run[NP];
  int            m_last[NP];
  int            m_cnt;
  bit            m_tick;
  logic [NP-1:0] s1d, s2d, s1i, s2i;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    assert (got === exp) passed++;
    else $error("FAIL %s: observed %0d expected %0d", tag, got, exp);
  endtask

  function automatic void model_edge();
    m_tick = 1'b0;
    if (reset) begin
      m_cnt = 0;
      s1d = '0; s2d = '0; s1i = '0; s2i = '0;
      for (int p = 0; p < NP; p++) begin
        m_pos[p] = INIT; m_run[p] = 0; m_last[p] = 0;
      end
      return;
    end
    m_tick = (m_cnt == TD - 1);
    m_cnt  = m_tick ? 0 : m_cnt + 1;
    for (int p = 0; p < NP; p++) begin
      int d;
      d = (s2i[p] && !s2d[p]) ? 1 : ((s2d[p] && !s2i[p]) ? -1 : 0);
      if (recenter) begin
        m_pos[p] = INIT; m_run[p] = 0;
      end else if (freeze) begin
        m_run[p] = 0;
      end else if (m_tick) begin
        if (d == 0) begin
          m_run[p] = 0;
        end else begin
          m_run[p]  = (d == m_last[p] && m_run[p] > 0) ? m_run[p] + 1 : 1;
          m_last[p] = d;
          m_pos[p]  = m_pos[p] + d * ((m_run[p] > ACC) ? SF : SS);
          if (m_pos[p] < 0) m_pos[p] = 0;
          if (m_pos[p] > MAXL) m_pos[p] = MAXL;
        end
      end
    end
    s2d = s1d; s1d = btn_dec;
    s2i = s1i; s1i = btn_inc;
  endfunction

  task automatic check_outputs();
    logic [NP*PW-1:0] el, ec;
    logic [NP-1:0]    em, emin, emax;
    for (int p = 0; p < NP; p++) begin
      el[p*PW +: PW] = PW'(m_pos[p]);
      ec[p*PW +: PW] = PW'(m_pos[p] + HALF - 1);
      em[p]   = (m_run[p] > 0);
      emin[p] = (m_pos[p] == 0);
      emax[p] = (m_pos[p] == MAXL);
    end
    chk("pos_left", 32'(pos_left), 32'(el));
    chk("pos_centre", 32'(pos_centre), 32'(ec));
    chk("moving", 32'(moving), 32'(em));
    chk("at_min", 32'(at_min), 32'(emin));
    chk("at_max", 32'(at_max), 32'(emax));
  endtask

  task automatic cycle();
    @(posedge clock);
    model_edge();
    #1;
    check_outputs();
  endtask

  task automatic run_ticks(input int n);
    int seen = 0;
    for (int c = 0; c < (n + 1) * TD && seen < n; c++) begin
      cycle();
      if (m_tick) seen++;
    end
  endtask

  initial begin
    // Reset
    repeat (3) cycle();
    reset = 1'b0;
    chk("rst_pos_left", 32'(pos_left), 32'({9'd100, 9'd100}));
    chk("rst_pos_centre", 32'(pos_centre), 32'({9'd119, 9'd119}));
    chk("rst_moving", 32'(moving), 32'd0);
    chk("rst_at_min", 32'(at_min), 32'd0);
    chk("rst_at_max", 32'(at_max), 32'd0);
    run_ticks(20);
    chk("idle_pos_left", 32'(pos_left), 32'({9'd100, 9'd100}));

    // Acceleration on paddle 0
    btn_inc = 2'b01;
    repeat (2) cycle();
    run_ticks(8);
    chk("accel_t8", 32'(pos_left[8:0]), 32'd108);
    chk("accel_moving", 32'(moving[0]), 32'd1);
    chk("accel_other", 32'(pos_left[17:9]), 32'd100);
    run_ticks(2);
    chk("accel_t10", 32'(pos_left[8:0]), 32'd114);

    // Reversal from FAST restarts slow
    btn_inc = 2'b00; btn_dec = 2'b01;
    repeat (2) cycle();
    run_ticks(1);
    chk("reverse_first", 32'(pos_left[8:0]), 32'd113);
    run_ticks(8);
    chk("reverse_reaccel", 32'(pos_left[8:0]), 32'd103);

    // Both buttons cancel
    btn_inc = 2'b01;
    repeat (2) cycle();
    run_ticks(1);
    chk("conflict_pos", 32'(pos_left[8:0]), 32'd103);
    chk("conflict_moving", 32'(moving[0]), 32'd0);

    // Recenter mid-FAST, between ticks
    btn_dec = 2'b00;
    repeat (2) cycle();
    run_ticks(21);
    chk("pre_recenter", 32'(pos_left[8:0]), 32'd150);
    cycle();
    recenter = 1'b1;
    cycle();
    recenter = 1'b0;
    chk("recenter_pos", 32'(pos_left[8:0]), 32'd100);
    chk("recenter_moving", 32'(moving[0]), 32'd0);

    // Reset mid-FAST
    run_ticks(9);
    chk("pre_reset", 32'(pos_left[8:0]), 32'd111);
    cycle();
    reset = 1'b1;
    cycle();
    reset = 1'b0; btn_inc = 2'b00;
    chk("midreset_pos", 32'(pos_left[8:0]), 32'd100);
    chk("midreset_moving", 32'(moving[0]), 32'd0);

    // Saturation at 0 then at MAX_LEFT on paddle 1
    btn_dec = 2'b10;
    repeat (2) cycle();
    run_ticks(39);
    chk("sat_min_pos", 32'(pos_left[17:9]), 32'd0);
    chk("sat_min_flag", 32'(at_min[1]), 32'd1);
    run_ticks(10);
    chk("sat_min_hold", 32'(pos_left[17:9]), 32'd0);
    btn_dec = 2'b00; btn_inc = 2'b10;
    repeat (2) cycle();
    run_ticks(72);
    chk("sat_max_pos", 32'(pos_left[17:9]), 32'd200);
    chk("sat_max_flag", 32'(at_max[1]), 32'd1);
    run_ticks(5);
    chk("sat_max_hold", 32'(pos_left[17:9]), 32'd200);

    // Freeze during FAST
    btn_inc = 2'b00; btn_dec = 2'b10;
    repeat (2) cycle();
    run_ticks(10);
    chk("pre_freeze", 32'(pos_left[17:9]), 32'd186);
    freeze = 1'b1;
    run_ticks(10);
    chk("freeze_pos", 32'(pos_left[17:9]), 32'd186);
    chk("freeze_moving", 32'(moving[1]), 32'd0);
    freeze = 1'b0;
    run_ticks(1);
    chk("thaw_step1", 32'(pos_left[17:9]), 32'd185);
    run_ticks(1);
    chk("thaw_step2", 32'(pos_left[17:9]), 32'd184);

    // Randomised traffic against the model
    for (int i = 0; i < 3000; i++) begin
      if ($urandom_range(39) == 0) btn_inc = NP'($urandom);
      if ($urandom_range(39) == 0) btn_dec = NP'($urandom);
      recenter = ($urandom_range(99) == 0);
      if (freeze) freeze = ($urandom_range(9) != 0);
      else        freeze = ($urandom_range(149) == 0);
      reset = ($urandom_range(499) == 0);
      cycle();
    end
    reset = 1'b0; recenter = 1'b0; freeze = 1'b0;
    cycle();

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule

// File: doc/paddle_array_ctrl.md
Name: paddle_array_ctrl

Overview:
Parametrised controller for N independently driven paddles along a 1-D playfield. It synchronises raw button inputs, steps positions on a frame-rate tick and accelerates from slow to fast speed after a sustained press. Positions saturate at the playfield bounds. Sits between the button/key inputs and the collision and render logic, which consume per-paddle left-edge and centre positions.

Parameters:
NUM_PADDLES, 2, number of paddle channels
POS_W, 9, position width in pixels
FIELD_MAX, 239, last valid pixel coordinate of the playfield
PADDLE_LEN, 40, paddle length in pixels
INIT_POS, 100, left-edge position after reset or recenter
TICK_DIV, 833333, clocks per movement tick (60 Hz at 50 MHz); 1 = tick every cycle
SPEED_SLOW, 1, pixels per tick in SLOW
SPEED_FAST, 3, pixels per tick in FAST
ACCEL_TICKS, 8, consecutive SLOW move ticks before promotion to FAST

Ports:
clock  in  1  system clock
reset  in  1  synchronous, active-high reset
btn_dec  in  NUM_PADDLES  raw async "move toward 0" button, one bit per paddle
btn_inc  in  NUM_PADDLES  raw async "move toward FIELD_MAX" button, one bit per paddle
freeze  in  1  hold all positions (pause); synchronous level
recenter  in  1  synchronous pulse; return all paddles to INIT_POS
pos_left  out  NUM_PADDLES*POS_W  registered left edge; paddle i occupies bits [i*POS_W +: POS_W]
pos_centre  out  NUM_PADDLES*POS_W  pos_left + PADDLE_LEN/2 - 1, combinational from pos_left
moving  out  NUM_PADDLES  1 when the channel FSM is not IDLE
at_min  out  NUM_PADDLES  1 when pos_left == 0
at_max  out  NUM_PADDLES  1 when pos_left == MAX_LEFT

Behaviour:
- Interface: reset is synchronous, active-high; clock is clock.
- MAX_LEFT = FIELD_MAX - PADDLE_LEN + 1 (200 at defaults).
- Elaboration check, fatal on failure: PADDLE_LEN <= FIELD_MAX+1; INIT_POS <= MAX_LEFT; SPEED_SLOW >= 1; SPEED_FAST >= SPEED_SLOW.
- Reset values: pos_left = INIT_POS for all paddles; FSM = IDLE; hold counters 0; tick counter 0; synchroniser flops 0. Consequently moving = 0, and at_min/at_max are derived from INIT_POS.
- Tick counter: 0..TICK_DIV-1. tick = (cnt == TICK_DIV-1); cnt wraps to 0 on the same edge. The counter runs during freeze.
- Buttons pass through a 2-flop synchroniser per bit. A raw edge becomes visible to the FSM 2 cycles later.
- Per channel, dir is taken from the synchronised buttons:
  - INC if only inc is high.
  - DEC if only dec is high.
  - NONE if neither is high, or if both are high.
- FSM states are IDLE, SLOW and FAST. It is evaluated only on tick edges, unless noted otherwise.
  - IDLE: if dir != NONE, step by SPEED_SLOW in dir, go to SLOW, set hold = 1, latch dir.
  - SLOW: dir == NONE goes to IDLE. A dir change from the latched dir steps SLOW in the new dir with hold = 1. Same dir steps SLOW and increments hold; when hold reaches ACCEL_TICKS, go to FAST.
  - FAST: same dir steps by SPEED_FAST. dir == NONE goes to IDLE. A dir change steps SLOW in the new dir, goes to SLOW, and sets hold = 1.
- The first move occurs on the tick that first sees dir != NONE. The position register updates on that edge.
- Step arithmetic is done at POS_W+1 bits and saturates:
  - DEC: new = (pos < step) ? 0 : pos - step.
  - INC: new = (pos + step > MAX_LEFT) ? MAX_LEFT : pos + step.
  - No wrap-around under any condition.
- Holding against a bound keeps the FSM in its state. Position stays at the bound, and acceleration continues to count.
- Priority per cycle, evaluated on every clock, not only on ticks:
  1. reset
  2. recenter
  3. freeze
  4. movement
- recenter: on the next edge, pos_left = INIT_POS and FSM = IDLE for all channels. Hold counters clear; tick counter unaffected.
- freeze high: positions hold and FSM is forced to IDLE with hold = 0. On release, motion restarts from IDLE, i.e. SLOW speed.
- Reset or recenter mid-FAST takes effect in one cycle regardless of tick phase.

Decomposition:
- Package paddle_pkg:
  - state enum {IDLE, SLOW, FAST} and dir enum {NONE, DEC, INC};
  - function max_left(field_max, len);
  - function for the hold-counter width, $clog2(ACCEL_TICKS+1).
- Sub-module paddle_channel: one per paddle via generate. It contains the synchroniser, FSM, hold counter, saturating position register and the at_min/at_max/moving/centre logic.
- The top level holds the shared tick divider, the freeze/recenter distribution and output packing.

Test Plan:
All tests use defaults except TICK_DIV=4.
- Reset: assert reset 3 cycles, release -> pos_left = 100/100, pos_centre = 119/119, moving = 00, at_min = at_max = 00. Idle for 20 ticks -> unchanged.
- Acceleration: hold btn_inc[0] -> position 101..108 over the first 8 ticks, then 111, 114 on ticks 9 and 10. moving[0] = 1; paddle 1 stays at 100.
- Saturation: hold btn_dec[1] from 100 -> reaches 0 (last FAST step 2 -> 0), at_min[1] = 1, stays 0 for 10 further ticks with no wrap to 511. Mirror test with btn_inc reaches 200, at_max = 1.
- Conflict and reversal: both buttons on paddle 0 -> no movement, moving = 0. In FAST, switch inc -> dec -> next tick steps -1, not -3, and re-accelerates after 8 ticks.
- Recenter and reset mid-motion: during FAST at 150, pulse recenter between ticks -> pos_left = 100 on the next edge, moving = 0. Repeat with reset -> same.
- Freeze: during FAST, freeze = 1 for 10 ticks -> position constant, moving = 0. Release with button held -> SLOW steps of 1 resume.
